// File: rtl/rx_dllp_scheduler.sv
// Receive-side DLLP scheduler: tracks the next expected TLP sequence number and
// schedules Nak, coalesced/timed Ack and UpdateFC DLLPs onto one registered output.
module rx_dllp_scheduler #(
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chk_valid,
  input  logic        chk_ok,
  input  logic        fc_update_req,
  input  logic [7:0]  fc_hdr_credit,
  input  logic [11:0] fc_data_credit,
  output logic [31:0] dllp,
  output logic        dllp_valid,
  input  logic        dllp_ready,
  output logic [11:0] next_rcv_seq
);

  typedef enum logic [1:0] {IDLE, SEND_NAK, SEND_ACK, SEND_FC} state_t;

  localparam logic [8:0]  COAL_LIM = 9'(ACK_COALESCE);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  pend_cnt;
  logic [15:0] timer;
  logic        nak_pend, nak_sched, fc_pend;
  logic        good, bad, ack_due;
  logic        launch_nak, launch_ack, launch_fc;
  logic [11:0] seq_m1;

  assign good    = chk_valid & chk_ok;
  assign bad     = chk_valid & ~chk_ok;
  assign seq_m1  = next_rcv_seq - 12'd1;
  // The pend_cnt guard keeps a zero timer from firing an empty Ack.
  assign ack_due = (pend_cnt != 8'd0) &&
                   (({1'b0, pend_cnt} >= COAL_LIM) || (timer == TMO_LAST));

  always_comb begin
    state_nxt  = state;
    launch_nak = 1'b0;
    launch_ack = 1'b0;
    launch_fc  = 1'b0;
    case (state)
      IDLE: begin
        if (nak_pend) begin
          state_nxt  = SEND_NAK;
          launch_nak = 1'b1;
        end else if (ack_due) begin
          state_nxt  = SEND_ACK;
          launch_ack = 1'b1;
        end else if (fc_pend) begin
          state_nxt  = SEND_FC;
          launch_fc  = 1'b1;
        end
      end
      default: begin
        if (dllp_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dllp         <= 32'h0;
      dllp_valid   <= 1'b0;
      next_rcv_seq <= 12'd0;
      pend_cnt     <= 8'd0;
      timer        <= 16'd0;
      nak_pend     <= 1'b0;
      nak_sched    <= 1'b0;
      fc_pend      <= 1'b0;
    end else begin
      state      <= state_nxt;
      dllp_valid <= (state_nxt != IDLE);

      if (launch_nak)
        dllp <= {8'h10, 8'h00, 4'h0, seq_m1};
      else if (launch_ack)
        dllp <= {8'h00, 8'h00, 4'h0, seq_m1};
      else if (launch_fc)
        dllp <= {8'h40, 2'b00, fc_hdr_credit, 2'b00, fc_data_credit};

      if (good) next_rcv_seq <= next_rcv_seq + 12'd1;

      // A TLP accepted on the launch edge starts the next Ack window.
      if (launch_nak || launch_ack)
        pend_cnt <= good ? 8'd1 : 8'd0;
      else if (good && pend_cnt != 8'hFF)
        pend_cnt <= pend_cnt + 8'd1;

      if (launch_nak || launch_ack || pend_cnt == 8'd0)
        timer <= 16'd0;
      else if (timer != TMO_LAST)
        timer <= timer + 16'd1;

      nak_pend <= (nak_pend & ~launch_nak) | (bad & ~nak_sched);
      if (good)
        nak_sched <= 1'b0;
      else if (bad)
        nak_sched <= 1'b1;

      fc_pend <= (fc_pend & ~launch_fc) | fc_update_req;
    end
  end

endmodule

// File: tb/tb_rx_dllp_scheduler.sv
// Directed bench for rx_dllp_scheduler: linear stimulus, hand-computed expectations,
// immediate assertions at each comparison.
module tb_rx_dllp_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        chk_valid, chk_ok, fc_update_req, dllp_ready;
  logic [7:0]  fc_hdr_credit;
  logic [11:0] fc_data_credit;
  logic [31:0] dllp;
  logic        dllp_valid;
  logic [11:0] next_rcv_seq;

  int vectors = 0;
  int miscompares = 0;
  int n;

  rx_dllp_scheduler #(.ACK_COALESCE(4), .ACK_TIMEOUT(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .chk_valid      (chk_valid),
    .chk_ok         (chk_ok),
    .fc_update_req  (fc_update_req),
    .fc_hdr_credit  (fc_hdr_credit),
    .fc_data_credit (fc_data_credit),
    .dllp           (dllp),
    .dllp_valid     (dllp_valid),
    .dllp_ready     (dllp_ready),
    .next_rcv_seq   (next_rcv_seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    chk_valid = 0; chk_ok = 0; fc_update_req = 0; dllp_ready = 1;
    fc_hdr_credit = 8'h00; fc_data_credit = 12'h000;
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  // Cycles until dllp_valid rises, bounded; returns limit+1 on timeout.
  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (cycles <= limit) begin
      tick();
      cycles++;
      if (dllp_valid) break;
    end
  endtask

  task automatic count_valid(input int span, output int cnt);
    cnt = 0;
    for (int i = 0; i < span; i++) begin
      tick();
      if (dllp_valid) cnt++;
    end
  endtask

  initial begin
    do_reset();
    check("reset_valid", 32'(dllp_valid), 32'd0);
    check("reset_dllp", dllp, 32'h0);
    check("reset_seq", 32'(next_rcv_seq), 32'd0);

    // Four consecutive good TLPs force one Ack for seq 3.
    chk_valid = 1; chk_ok = 1;
    repeat (4) tick();
    chk_valid = 0;
    check("coal_seq", 32'(next_rcv_seq), 32'd4);
    check("coal_pre_valid", 32'(dllp_valid), 32'd0);
    tick();
    check("coal_valid", 32'(dllp_valid), 32'd1);
    check("coal_dllp", dllp, 32'h0000_0003);
    tick();
    check("coal_gap", 32'(dllp_valid), 32'd0);
    count_valid(20, n);
    check("coal_single_ack", 32'(n), 32'd0);

    // One good TLP then silence: timeout Ack 16 edges later.
    do_reset();
    chk_valid = 1; chk_ok = 1;
    tick();
    chk_valid = 0;
    wait_valid(40, n);
    check("tmo_latency", 32'(n), 32'd16);
    check("tmo_dllp", dllp, 32'h0000_0000);
    tick();
    check("tmo_done", 32'(dllp_valid), 32'd0);

    // Good, bad, bad, good: one Nak; the later good re-arms Nak for a new bad TLP.
    do_reset();
    chk_valid = 1; chk_ok = 1; tick();
    chk_ok = 0; tick();
    tick();
    check("nak1_valid", 32'(dllp_valid), 32'd1);
    check("nak1_dllp", dllp, 32'h1000_0000);
    chk_ok = 1; tick();
    check("nak1_done", 32'(dllp_valid), 32'd0);
    check("nak_seq", 32'(next_rcv_seq), 32'd2);
    chk_ok = 0; tick();
    check("nak_gap", 32'(dllp_valid), 32'd0);
    chk_valid = 0; tick();
    check("nak2_valid", 32'(dllp_valid), 32'd1);
    check("nak2_dllp", dllp, 32'h1000_0001);
    tick();
    check("nak2_done", 32'(dllp_valid), 32'd0);
    count_valid(25, n);
    check("nak_no_ack", 32'(n), 32'd0);

    // UpdateFC held under backpressure; hdr lands at bits 21:14, data at 11:0.
    do_reset();
    dllp_ready = 0;
    fc_hdr_credit = 8'h20; fc_data_credit = 12'h100; fc_update_req = 1;
    tick();
    fc_update_req = 0;
    tick();
    fc_hdr_credit = 8'hFF; fc_data_credit = 12'hFFF;
    check("fc_valid", 32'(dllp_valid), 32'd1);
    check("fc_dllp", dllp, 32'h4008_0100);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dllp_valid && dllp == 32'h4008_0100) n++;
    end
    check("fc_stable", 32'(n), 32'd5);
    dllp_ready = 1;
    tick();
    check("fc_done", 32'(dllp_valid), 32'd0);

    // Nak, Ack and FC all pending together: Nak, then FC, and no Ack.
    do_reset();
    dllp_ready = 0;
    fc_hdr_credit = 8'h20; fc_data_credit = 12'h100; fc_update_req = 1;
    tick();
    fc_update_req = 0;
    tick();
    check("pri_fc1", dllp, 32'h4008_0100);
    fc_hdr_credit = 8'h05; fc_data_credit = 12'hABC;
    chk_valid = 1; chk_ok = 1;
    repeat (4) tick();
    chk_ok = 0; fc_update_req = 1;
    tick();
    chk_valid = 0; fc_update_req = 0; dllp_ready = 1;
    tick();
    check("pri_gap", 32'(dllp_valid), 32'd0);
    tick();
    check("pri_nak_valid", 32'(dllp_valid), 32'd1);
    check("pri_nak_dllp", dllp, 32'h1000_0003);
    tick();
    check("pri_gap2", 32'(dllp_valid), 32'd0);
    tick();
    check("pri_fc_valid", 32'(dllp_valid), 32'd1);
    check("pri_fc_dllp", dllp, 32'h4001_4ABC);
    tick();
    count_valid(25, n);
    check("pri_no_ack", 32'(n), 32'd0);

    // Reset during a stalled DLLP drops it.
    do_reset();
    dllp_ready = 0;
    fc_update_req = 1; tick();
    fc_update_req = 0; tick();
    check("rst_mid_pre", 32'(dllp_valid), 32'd1);
    reset = 1;
    #1;
    check("rst_mid_valid", 32'(dllp_valid), 32'd0);
    check("rst_mid_dllp", dllp, 32'h0);
    @(negedge clk);
    reset = 0;
    count_valid(5, n);
    check("rst_mid_dropped", 32'(n), 32'd0);

    // Sequence wrap: 4095 good TLPs, drain, then one more.
    do_reset();
    chk_valid = 1; chk_ok = 1;
    repeat (4095) tick();
    chk_valid = 0;
    check("wrap_pre_seq", 32'(next_rcv_seq), 32'd4095);
    repeat (40) tick();
    chk_valid = 1;
    tick();
    chk_valid = 0;
    check("wrap_seq", 32'(next_rcv_seq), 32'd0);
    wait_valid(40, n);
    check("wrap_latency", 32'(n), 32'd16);
    check("wrap_dllp", dllp, 32'h0000_0FFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
